// File: rtl/j_uart_peer.sv
// Far-end serial peer for JERRY UART2: 16x-oversampled TX/RX, RX FIFO with parity/framing/overflow flags.
// Line starts 1 clk after accept; RX byte is pushed 1 clk after the stop sample. tx_ready low while busy; full FIFO drops + rx_ovf.
// Optional break detection (rx_brk, BRKWAIT) under UART_PEER_BREAK_EN.
module j_uart_peer #(
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             resetl,
   input  logic [DIV_W-1:0] div,
   input  logic             par_en,
   input  logic             par_odd,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             serial_out,
   input  logic             serial_in,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             rx_perr,
   output logic             rx_ferr,
   output logic             rx_ovf,
   input  logic             clr_ovf,
   output logic             rx_brk
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);
   localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_PUSH
`ifdef UART_PEER_BREAK_EN
      , RX_BRKWAIT
`endif
   } rx_state_e;

   tx_state_e        tx_state_q, tx_state_d;
   logic [DIV_W-1:0] tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
   logic [3:0]       tx_sub_q, tx_sub_d;
   logic [2:0]       tx_bit_q, tx_bit_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
   logic             tx_tick, tx_bit_end;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_pen_d   = tx_pen_q;
      tx_tick    = (tx_cnt_q == tx_div_q);
      tx_bit_end = tx_tick && (tx_sub_q == 4'd15);
      tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + CNT_ONE;
      tx_sub_d   = tx_tick ? tx_sub_q + 4'd1 : tx_sub_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            tx_sub_d = '0;
            if (tx_valid) begin
               tx_state_d = TX_START;
               tx_div_d   = div;
               tx_shift_d = tx_data;
               tx_par_d   = (^tx_data) ^ par_odd;
               tx_pen_d   = par_en;
               tx_bit_d   = '0;
            end
         end
         TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = tx_pen_q ? TX_PAR : TX_STOP;
            end
         end
         TX_PAR:  if (tx_bit_end) tx_state_d = TX_STOP;
         TX_STOP: if (tx_bit_end) tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Line is decoded from state so reset forces it high without waiting for a clock.
   always_comb begin
      serial_out = 1'b1;
      case (tx_state_q)
         TX_START: serial_out = 1'b0;
         TX_DATA:  serial_out = tx_shift_q[0];
         TX_PAR:   serial_out = tx_par_q;
         default:  serial_out = 1'b1;
      endcase
   end
   assign tx_ready = (tx_state_q == TX_IDLE);

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         tx_state_q <= TX_IDLE;
         tx_div_q   <= '0;
         tx_cnt_q   <= '0;
         tx_sub_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_pen_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_div_q   <= tx_div_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_sub_q   <= tx_sub_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_pen_q   <= tx_pen_d;
      end
   end

   rx_state_e        rx_state_q, rx_state_d;
   logic             rx_s1_q, rx_s2_q, rx_prev_q, rx_line;
   logic [DIV_W-1:0] rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
   logic [3:0]       rx_sub_q, rx_sub_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
   logic             rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
   logic             rx_tick, rx_centre, rx_push;
`ifdef UART_PEER_BREAK_EN
   logic             rx_brk_q, rx_brk_d, rx_brk_set;
`endif

   assign rx_line = rx_s2_q;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_div_d   = rx_div_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_pen_d   = rx_pen_q;
      rx_odd_d   = rx_odd_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_push    = 1'b0;
`ifdef UART_PEER_BREAK_EN
      rx_brk_set = 1'b0;
`endif
      rx_tick    = (rx_cnt_q == rx_div_q);
      rx_centre  = rx_tick && (rx_sub_q == 4'd15);
      rx_cnt_d   = rx_tick ? '0 : rx_cnt_q + CNT_ONE;
      rx_sub_d   = rx_tick ? rx_sub_q + 4'd1 : rx_sub_q;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            rx_sub_d = '0;
            if (rx_prev_q && !rx_line) begin
               rx_state_d = RX_START;
               rx_div_d   = div;
               rx_pen_d   = par_en;
               rx_odd_d   = par_odd;
               rx_perr_d  = 1'b0;
               rx_ferr_d  = 1'b0;
               rx_bit_d   = '0;
            end
         end
         // Mid-start sample realigns the tick counter so later samples land on bit centres.
         RX_START: begin
            if (rx_tick && (rx_sub_q == 4'd7)) begin
               rx_sub_d   = '0;
               rx_state_d = rx_line ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_centre) begin
               rx_shift_d = {rx_line, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = rx_pen_q ? RX_PAR : RX_STOP;
            end
         end
         RX_PAR: begin
            if (rx_centre) begin
               rx_perr_d  = rx_line ^ (^rx_shift_q) ^ rx_odd_q;
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_centre) begin
               rx_ferr_d = !rx_line;
`ifdef UART_PEER_BREAK_EN
               if (!rx_line && (rx_shift_q == 8'h00)) begin
                  rx_brk_set = 1'b1;
                  rx_state_d = RX_BRKWAIT;
               end else begin
                  rx_state_d = RX_PUSH;
               end
`else
               rx_state_d = RX_PUSH;
`endif
            end
         end
         RX_PUSH: begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
         end
`ifdef UART_PEER_BREAK_EN
         RX_BRKWAIT: begin
            if (!rx_line) begin
               rx_cnt_d = '0;
               rx_sub_d = '0;
            end else if (rx_centre) begin
               rx_state_d = RX_IDLE;
            end
         end
`endif
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_div_q   <= '0;
         rx_cnt_q   <= '0;
         rx_sub_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_pen_q   <= 1'b0;
         rx_odd_q   <= 1'b0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_s1_q    <= serial_in;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_div_q   <= rx_div_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_sub_q   <= rx_sub_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_pen_q   <= rx_pen_d;
         rx_odd_q   <= rx_odd_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   logic [9:0]  fifo_mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_full, fifo_pop, fifo_wr, rx_ovf_q, rx_ovf_d;

   assign rx_valid  = (wr_ptr_q != rd_ptr_q);
   assign fifo_full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign fifo_pop  = rx_valid && rx_ready;
   assign fifo_wr   = rx_push && (!fifo_full || fifo_pop);
   assign {rx_perr, rx_ferr, rx_data} = fifo_mem_q[rd_ptr_q[AW-1:0]];
   assign rx_ovf_d  = !clr_ovf && (rx_ovf_q || (rx_push && !fifo_wr));
   assign rx_ovf    = rx_ovf_q;
`ifdef UART_PEER_BREAK_EN
   assign rx_brk_d  = !clr_ovf && (rx_brk_q || rx_brk_set);
   assign rx_brk    = rx_brk_q;
`else
   assign rx_brk    = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rx_ovf_q <= 1'b0;
`ifdef UART_PEER_BREAK_EN
         rx_brk_q <= 1'b0;
`endif
      end else begin
         if (fifo_wr) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= {rx_perr_q, rx_ferr_q, rx_shift_q};
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         rx_ovf_q <= rx_ovf_d;
`ifdef UART_PEER_BREAK_EN
         rx_brk_q <= rx_brk_d;
`endif
      end
   end
endmodule

// File: tb/tb_j_uart_peer.sv
// Directed bench for j_uart_peer: TX waveform, loopback, injected error frames, overflow, glitch, reset, break.
module tb_j_uart_peer;
   logic        clk = 1'b0;
   logic        resetl;
   logic [15:0] div;
   logic        par_en, par_odd;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, serial_out, serial_in;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready, rx_perr, rx_ferr, rx_ovf, clr_ovf, rx_brk;
   logic        loop_en, inj_line;
   int          n_chk = 0;
   int          n_bad = 0;

   assign serial_in = loop_en ? serial_out : inj_line;
   always #5 clk = ~clk;

   j_uart_peer #(.DIV_W(16), .FIFO_DEPTH(8)) dut (
      .clk(clk), .resetl(resetl), .div(div), .par_en(par_en), .par_odd(par_odd),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .serial_out(serial_out), .serial_in(serial_in),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_ovf(rx_ovf),
      .clr_ovf(clr_ovf), .rx_brk(rx_brk)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tx_ready();
      int t = 0;
      while (!tx_ready && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("tx_ready_timeout", tx_ready, 1);
   endtask

   // Returns on the first falling edge after the accepting clock edge.
   task automatic send_byte(input logic [7:0] d);
      wait_tx_ready();
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic pop();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   // expb bit 0 is the start bit; samples each bit at its centre.
   task automatic tx_frame(input logic [7:0] d, input int bitlen, input logic [10:0] expb, input int nbits);
      send_byte(d);
      chk("tx_ready_drop", tx_ready, 0);
      chk("tx_start_now", serial_out, 0);
      for (int n = 1; n <= nbits * bitlen + 1; n++) begin
         if (n > 1) @(negedge clk);
         if (n % bitlen == bitlen / 2) chk("tx_bit", serial_out, expb[(n-1)/bitlen]);
         if (n == bitlen) chk("tx_start_last", serial_out, 0);
         if (n == bitlen + 1) chk("tx_bit0_first", serial_out, expb[1]);
         if (n == nbits * bitlen) chk("tx_ready_stop", tx_ready, 0);
         if (n == nbits * bitlen + 1) chk("tx_ready_rise", tx_ready, 1);
      end
   endtask

   task automatic inject(input logic [11:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         inj_line = bits[i];
         cycles(16 * (int'(div) + 1));
      end
      inj_line = 1'b1;
   endtask

   initial begin
      resetl = 1'b0; div = '0; par_en = 1'b0; par_odd = 1'b0;
      tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr_ovf = 1'b0;
      loop_en = 1'b0; inj_line = 1'b1;
      cycles(3);
      chk("rst_serial_out", serial_out, 1);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_perr", rx_perr, 0);
      chk("rst_ferr", rx_ferr, 0);
      chk("rst_ovf", rx_ovf, 0);
      chk("rst_brk", rx_brk, 0);
      resetl = 1'b1;
      cycles(2);

      // 0xA5, no parity, div=0
      tx_frame(8'hA5, 16, {1'b0, 1'b1, 8'hA5, 1'b0}, 10);
      chk("t1_no_rx", rx_valid, 0);

      // loopback 0x3C, odd parity, div=3
      loop_en = 1'b1; div = 16'd3; par_en = 1'b1; par_odd = 1'b1;
      tx_frame(8'h3C, 64, {1'b1, 1'b1, 8'h3C, 1'b0}, 11);
      chk("t2_valid", rx_valid, 1);
      chk("t2_data", rx_data, 8'h3C);
      chk("t2_perr", rx_perr, 0);
      chk("t2_ferr", rx_ferr, 0);
      pop();
      chk("t2_empty", rx_valid, 0);

      // injected parity error (even parity bit while odd expected), then framing error
      loop_en = 1'b0; div = 16'd0;
      inject({1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
      cycles(6);
      chk("t3_valid", rx_valid, 1);
      chk("t3_data", rx_data, 8'h3C);
      chk("t3_perr", rx_perr, 1);
      chk("t3_ferr", rx_ferr, 0);
      pop();
      par_en = 1'b0;
      inject({2'b00, 1'b0, 8'h55, 1'b0}, 10);
      cycles(6);
      chk("t3f_valid", rx_valid, 1);
      chk("t3f_data", rx_data, 8'h55);
      chk("t3f_ferr", rx_ferr, 1);
      chk("t3f_perr", rx_perr, 0);
      pop();
      chk("t3_empty", rx_valid, 0);

      // overflow: nine bytes into an eight-entry FIFO
      loop_en = 1'b1;
      for (int i = 1; i <= 9; i++) send_byte(8'(i));
      cycles(200);
      chk("t4_ovf", rx_ovf, 1);
      for (int i = 1; i <= 8; i++) begin
         chk("t4_valid", rx_valid, 1);
         chk("t4_order", rx_data, i);
         pop();
      end
      chk("t4_empty", rx_valid, 0);
      chk("t4_ovf_sticky", rx_ovf, 1);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("t4_ovf_clr", rx_ovf, 0);

      // 4-clock glitch is rejected, following frame still received
      loop_en = 1'b0;
      inj_line = 1'b0;
      cycles(4);
      inj_line = 1'b1;
      cycles(40);
      chk("t5_glitch", rx_valid, 0);
      inject({2'b00, 1'b1, 8'h7E, 1'b0}, 10);
      cycles(6);
      chk("t5_valid", rx_valid, 1);
      chk("t5_data", rx_data, 8'h7E);
      chk("t5_ferr", rx_ferr, 0);
      pop();

      // reset mid-frame clears FIFO and forces the line high at once
      loop_en = 1'b1;
      send_byte(8'h12);
      wait_tx_ready();
      cycles(20);
      chk("t6_pre_fifo", rx_valid, 1);
      send_byte(8'hFF);
      cycles(60);
      chk("t6_busy", tx_ready, 0);
      resetl = 1'b0;
      #1;
      chk("t6_rst_line", serial_out, 1);
      chk("t6_rst_fifo", rx_valid, 0);
      chk("t6_rst_data", rx_data, 0);
      @(negedge clk);
      resetl = 1'b1;
      @(negedge clk);
      chk("t6_tx_ready", tx_ready, 1);
      chk("t6_line_idle", serial_out, 1);
      cycles(200);
      chk("t6_no_partial", rx_valid, 0);

      // 0x00 with stop=0
      loop_en = 1'b0;
      inject({2'b00, 1'b0, 8'h00, 1'b0}, 10);
      cycles(6);
`ifdef UART_PEER_BREAK_EN
      chk("t7_brk", rx_brk, 1);
      chk("t7_no_push", rx_valid, 0);
      cycles(40);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("t7_brk_clr", rx_brk, 0);
`else
      chk("t7_valid", rx_valid, 1);
      chk("t7_data", rx_data, 8'h00);
      chk("t7_ferr", rx_ferr, 1);
      chk("t7_brk_tied", rx_brk, 0);
      pop();
      cycles(40);
`endif
      inject({2'b00, 1'b1, 8'h5A, 1'b0}, 10);
      cycles(6);
      chk("t7_after_valid", rx_valid, 1);
      chk("t7_after_data", rx_data, 8'h5A);
      pop();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
